chunked_serial_adder: RTL

- Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock.
- Carry is registered between chunks, so the critical path is one CHUNK-bit ripple instead of the full WIDTH-bit ripple.
- Sits beside the combinational adders as the area/timing-friendly option for wide datapaths.
- Valid/ready handshake on input and output; one operation in flight at a time.

---
 rtl/chunked_adder_pkg.sv | 22 ++
 rtl/chunk_ripple_adder.sv | 27 ++
 rtl/chunked_serial_adder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Holds the controller state encoding and the chunk-index width helper.
package chunked_adder_pkg;

  // Controller states: waiting for operands, adding chunks, holding result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the chunk index register; never narrower than one bit so a
  // single-chunk configuration still has a legal register.
  function automatic int idx_width(input int nchunk);
    if (nchunk <= 1) begin
      return 1;
    end else begin
      return $clog2(nchunk);
    end
  endfunction

endpackage : chunked_adder_pkg

// File: rtl/chunk_ripple_adder.sv
// Purely combinational CHUNK-bit ripple-carry adder built from 1-bit full
// adders. The serial adder reuses one instance for every chunk.
module chunk_ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry_s;

  // Ripple the carry through CHUNK full adders, LSB first.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[CHUNK];
  end

endmodule : chunk_ripple_adder

// File: rtl/chunked_serial_adder.sv
// Multi-cycle unsigned adder: {cout,sum} = a + b + cin, processed CHUNK bits
// per clock with the carry registered between chunks, so the critical path
// is a single CHUNK-bit ripple. Valid/ready on both sides, one operation in
// flight.
// Optional build macro CHUNKED_ADDER_OVF_EN adds the 'ovf' output (signed
// two's-complement overflow, registered with cout).
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);

  state_e             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef CHUNKED_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0]   a_chunk_s;
  logic [CHUNK-1:0]   b_chunk_s;
  logic [CHUNK-1:0]   chunk_sum_s;
  logic               chunk_cout_s;
  logic               last_chunk_s;
  logic [WIDTH-1:0]   sum_wr_s;
  logic               carry_into_msb_s;

  // The latched operands are shifted right once per chunk, so the chunk
  // being added is always the low CHUNK bits; no wide operand mux is needed.
  assign a_chunk_s    = a_q[CHUNK-1:0];
  assign b_chunk_s    = b_q[CHUNK-1:0];
  assign last_chunk_s = (idx_q == IDXW'(NCHUNK - 1));

  chunk_ripple_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_q),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // On the last chunk the adder's top bit is the word MSB; recover the carry
  // that entered it from the MSB sum bit and operand bits.
  always_comb begin
    carry_into_msb_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  end

  // Merge the current chunk result into its slot; other slots keep prior bits.
  always_comb begin
    sum_wr_s = sum_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        sum_wr_s[i*CHUNK +: CHUNK] = chunk_sum_s;
      end else begin
        sum_wr_s[i*CHUNK +: CHUNK] = sum_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Controller: accept in IDLE, one chunk per cycle in BUSY, hold in DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_cout_s;
        sum_d   = sum_wr_s;
        if (last_chunk_s) begin
          cout_d      = chunk_cout_s;
`ifdef CHUNKED_ADDER_OVF_EN
          ovf_d       = carry_into_msb_s ^ chunk_cout_s;
`endif
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = ST_DONE;
        end else begin
          idx_d       = idx_q + IDXW'(1);
          state_d     = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        idx_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CHUNKED_ADDER_OVF_EN
  // Overflow flag register, captured together with cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Overflow path not built; keep the MSB-carry term visibly consumed.
  logic unused_ovf_s;
  assign unused_ovf_s = carry_into_msb_s;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : chunked_serial_adder
